// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters (VGA fetcher,
// CPU load/store unit) and the single-port block RAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // VGA pixel fetcher (read-only)
    logic              vga_blank;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    // CPU load/store unit
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Block RAM command/response
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  vga_blank, vga_req, vga_addr,
        output vga_ack, vga_rvalid, vga_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    // Requester / RAM side
    modport master (
        output vga_blank, vga_req, vga_addr,
        input  vga_ack, vga_rvalid, vga_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port video RAM between the VGA fetcher and the CPU.
// One grant per clock, registered RAM command, read data returned to the
// owner exactly two cycles after its ack. A starvation counter forces a
// waiting CPU request through after CPU_MAX_WAIT lost cycles.
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic           inCLK_50MHZ,
    input  logic           BTN_NORTH,
    vram_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(CPU_MAX_WAIT);

    logic              vga_gnt;
    logic              cpu_gnt;
    logic              cpu_first;

    logic [3:0]        starve_q,   starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q,   mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // Read tags: bit 1 = VGA read, bit 0 = CPU read
    logic [1:0]        tag_p1_q,   tag_p1_d;
    logic [1:0]        tag_p2_q;

    // Grant: CPU wins during blanking or once it has starved long enough;
    // no grants are issued while reset is held.
    always_comb begin
        cpu_first = bus.cpu_req && (bus.vga_blank || (starve_q == STARVE_MAX));
        vga_gnt   = !BTN_NORTH && bus.vga_req && !cpu_first;
        cpu_gnt   = !BTN_NORTH && bus.cpu_req && !vga_gnt;
    end

    assign bus.vga_ack = vga_gnt;
    assign bus.cpu_ack = cpu_gnt;

    // Starvation counter next state: count lost CPU cycles, saturating.
    always_comb begin
        starve_d = starve_q;
        if (!bus.cpu_req || cpu_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Command next state: load the granted request, hold address/data when idle.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        tag_p1_d    = 2'b00;
        if (vga_gnt) begin
            mem_addr_d = bus.vga_addr;
            tag_p1_d   = 2'b10;
        end else if (cpu_gnt) begin
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            mem_we_d    = bus.cpu_we;
            tag_p1_d    = {1'b0, !bus.cpu_we};
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge inCLK_50MHZ or posedge BTN_NORTH) begin
        if (BTN_NORTH) begin
            starve_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            tag_p1_q    <= 2'b00;
            tag_p2_q    <= 2'b00;
        end else begin
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tag_p1_q    <= tag_p1_d;
            tag_p2_q    <= tag_p1_q;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

    assign bus.vga_rvalid = tag_p2_q[1];
    assign bus.cpu_rvalid = tag_p2_q[0];
    assign bus.vga_rdata  = bus.mem_rdata;
    assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small synchronous RAM model.
module tb_vram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_MAX_WAIT(4)) dut (
        .inCLK_50MHZ (clk),
        .BTN_NORTH   (rst),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle synchronous read, read-before-write
    logic [DATA_W-1:0] ram [0:255];
    logic [DATA_W-1:0] ram_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        ram_rdata <= ram[bus.mem_addr[7:0]];
    end
    assign bus.mem_rdata = ram_rdata;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.vga_blank = 1'b0;
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        // Reset state
        next_cycle();
        next_cycle();
        chk("rst_mem_addr",   32'(bus.mem_addr),   32'h0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'h0);
        chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'h0);
        chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'h0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        chk("rst_vga_ack",    32'(bus.vga_ack),    32'h0);
        chk("rst_cpu_ack",    32'(bus.cpu_ack),    32'h0);
        rst = 1'b0;

        // Preload 0x0100..0x0103 with 0xA000..0xA003 via back-to-back CPU writes
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
            bus.cpu_addr = 16'h0100 + 16'(i); bus.cpu_wdata = 16'hA000 + 16'(i);
            #1;
            chk($sformatf("preload_ack%0d", i), 32'(bus.cpu_ack), 32'h1);
        end

        // Single CPU write 0x0010 <= 0xBEEF
        next_cycle();
        bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
        #1;
        chk("wr_cpu_ack", 32'(bus.cpu_ack), 32'h1);
        chk("wr_vga_ack", 32'(bus.vga_ack), 32'h0);
        next_cycle();
        bus.cpu_req = 1'b0;
        #1;
        chk("wr_mem_we",     32'(bus.mem_we),     32'h1);
        chk("wr_mem_addr",   32'(bus.mem_addr),   32'h0010);
        chk("wr_mem_wdata",  32'(bus.mem_wdata),  32'hBEEF);
        chk("wr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);

        // CPU read-back of 0x0010
        next_cycle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        #1;
        chk("rd_cpu_ack",      32'(bus.cpu_ack),    32'h1);
        chk("wr_no_rvalid",    32'(bus.cpu_rvalid), 32'h0);
        chk("idle_mem_we",     32'(bus.mem_we),     32'h0);
        chk("idle_mem_addr",   32'(bus.mem_addr),   32'h0010);
        next_cycle();
        bus.cpu_req = 1'b0;
        #1;
        chk("rd_rvalid_n1",    32'(bus.cpu_rvalid), 32'h0);
        chk("rd_mem_we",       32'(bus.mem_we),     32'h0);
        next_cycle();
        #1;
        chk("rd_rvalid_n2",    32'(bus.cpu_rvalid), 32'h1);
        chk("rd_cpu_rdata",    32'(bus.cpu_rdata),  32'hBEEF);
        chk("rd_vga_rvalid",   32'(bus.vga_rvalid), 32'h0);
        next_cycle();
        #1;
        chk("rd_rvalid_n3",    32'(bus.cpu_rvalid), 32'h0);

        // Active video, both requesting: VGA x4 then forced CPU, repeating
        for (int k = 0; k < 10; k++) begin
            logic exp_cpu, exp_vrv, exp_crv;
            next_cycle();
            bus.vga_blank = 1'b0;
            bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
            #1;
            exp_cpu = (k % 5) == 4;
            exp_crv = (k >= 2) && ((k - 2) % 5 == 4);
            exp_vrv = (k >= 2) && !exp_crv;
            chk($sformatf("starve_vga_ack%0d", k), 32'(bus.vga_ack), 32'(!exp_cpu));
            chk($sformatf("starve_cpu_ack%0d", k), 32'(bus.cpu_ack), 32'(exp_cpu));
            chk($sformatf("starve_vga_rv%0d", k),  32'(bus.vga_rvalid), 32'(exp_vrv));
            chk($sformatf("starve_cpu_rv%0d", k),  32'(bus.cpu_rvalid), 32'(exp_crv));
            if (exp_vrv) chk($sformatf("starve_vga_rd%0d", k), 32'(bus.vga_rdata), 32'hA000);
            if (exp_crv) chk($sformatf("starve_cpu_rd%0d", k), 32'(bus.cpu_rdata), 32'hBEEF);
        end
        next_cycle();
        bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        next_cycle();

        // Blanking: CPU wins whenever it requests
        for (int k = 0; k < 5; k++) begin
            logic creq;
            creq = (k != 2) && (k != 4);
            next_cycle();
            bus.vga_blank = 1'b1;
            bus.vga_req = 1'b1;
            bus.cpu_req = creq;
            #1;
            chk($sformatf("blank_cpu_ack%0d", k), 32'(bus.cpu_ack), 32'(creq));
            chk($sformatf("blank_vga_ack%0d", k), 32'(bus.vga_ack), 32'(!creq));
        end
        next_cycle();
        bus.vga_blank = 1'b0; bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        next_cycle();

        // VGA back-to-back reads 0x0100..0x0103
        for (int j = 0; j < 7; j++) begin
            logic exp_rv;
            next_cycle();
            bus.vga_req  = (j < 4);
            bus.vga_addr = 16'h0100 + 16'(j);
            #1;
            exp_rv = (j >= 2) && (j <= 5);
            chk($sformatf("b2b_vga_ack%0d", j), 32'(bus.vga_ack), 32'(j < 4));
            chk($sformatf("b2b_vga_rv%0d", j),  32'(bus.vga_rvalid), 32'(exp_rv));
            if (exp_rv) chk($sformatf("b2b_vga_rd%0d", j), 32'(bus.vga_rdata), 32'hA000 + 32'(j - 2));
        end

        // Reset with a VGA read in flight
        next_cycle();
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0101;
        #1;
        chk("rflt_vga_ack", 32'(bus.vga_ack), 32'h1);
        next_cycle();
        bus.vga_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rflt_mem_addr",   32'(bus.mem_addr),   32'h0);
        chk("rflt_mem_we",     32'(bus.mem_we),     32'h0);
        chk("rflt_mem_wdata",  32'(bus.mem_wdata),  32'h0);
        chk("rflt_vga_rvalid", 32'(bus.vga_rvalid), 32'h0);
        chk("rflt_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        chk("rflt_vga_ack0",   32'(bus.vga_ack),    32'h0);
        chk("rflt_cpu_ack0",   32'(bus.cpu_ack),    32'h0);
        next_cycle();
        #1;
        chk("rflt_drop_rv",    32'(bus.vga_rvalid), 32'h0);
        chk("rflt_drop_crv",   32'(bus.cpu_rvalid), 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rflt_post_rv",    32'(bus.vga_rvalid), 32'h0);
        next_cycle();
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0102;
        #1;
        chk("post_vga_ack", 32'(bus.vga_ack), 32'h1);
        next_cycle();
        bus.vga_req = 1'b0;
        #1;
        chk("post_rv_n1", 32'(bus.vga_rvalid), 32'h0);
        next_cycle();
        #1;
        chk("post_rv_n2", 32'(bus.vga_rvalid), 32'h1);
        chk("post_rdata", 32'(bus.vga_rdata),  32'hA002);
        next_cycle();
        #1;
        chk("post_rv_n3", 32'(bus.vga_rvalid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video/data block RAM between the VGA pixel fetcher (read-only, deadline-critical) and the CPU load/store unit (read/write).
- Sits between the CPU datapath, the VGA controller and the RAM inside Top.
- Grants one access per clock, registers the RAM command, and routes read data back to the owner with a fixed 2-cycle latency.
- A starvation counter guarantees the CPU bounded service during active video.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 16, RAM data width.
- CPU_MAX_WAIT, 4, consecutive lost cycles a pending CPU request may suffer before it is forced through (legal range 1..15).

Ports:
- inCLK_50MHZ  in  1  system clock; all state changes on the rising edge.
- BTN_NORTH  in  1  reset, asynchronous, active-high.
- vga_blank  in  1  1 = VGA in blanking interval (CPU gets priority), 0 = active video (VGA gets priority).
- vga_req  in  1  VGA read request; vga_addr held valid while high.
- vga_addr  in  ADDR_W  VGA read address.
- vga_ack  out  1  combinational grant; request consumed at this clock edge.
- vga_rvalid  out  1  registered; vga_rdata valid this cycle.
- vga_rdata  out  DATA_W  read data (mem_rdata passthrough).
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  combinational grant.
- cpu_rvalid  out  1  registered; cpu_rdata valid this cycle (reads only).
- cpu_rdata  out  DATA_W  read data (mem_rdata passthrough).
- mem_addr  out  ADDR_W  registered RAM address.
- mem_we  out  1  registered RAM write enable.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_addr.

Behaviour:
- Reset (async, any time): mem_addr=0, mem_we=0, mem_wdata=0, starve counter=0, read-tag pipeline cleared, so vga_rvalid=cpu_rvalid=0. Reads in flight when reset asserts are dropped; no rvalid pulse after reset releases.
- Grant logic, combinational, per cycle:
  - Only vga_req: grant VGA.
  - Only cpu_req: grant CPU.
  - Neither: idle.
  - Both, vga_blank=1: grant CPU.
  - Both, vga_blank=0: grant VGA, unless starve==CPU_MAX_WAIT, then grant CPU.
- Exactly one ack at most per cycle; ack is never high without the matching req.
- Starve counter: increments when cpu_req=1 and not granted; clears when CPU is granted or cpu_req=0; saturates at CPU_MAX_WAIT.
- Handshake: req, addr, we and wdata are sampled at the edge where ack=1. The requester may present a new request in the very next cycle, so back-to-back grants to the same requester are legal (VGA full bandwidth). Request fields must stay stable while req=1 and ack=0.
- Command stage (edge ending grant cycle N): mem_addr, mem_we and mem_wdata load the granted request. mem_we=1 only for a CPU write.
  - Idle cycle: mem_we=0, mem_addr and mem_wdata hold their previous values.
- Return stage: the tag (vga/cpu/none) registered with the command is delayed one more cycle. The matching rvalid is high in cycle N+2 with rdata = mem_rdata.
  - CPU writes produce no rvalid.
  - Read latency is exactly 2 cycles from ack, in all cases.
- Ordering: the RAM is single-port, so a CPU write granted in cycle N is visible to any read granted in cycle N+1 or later.
- vga_blank is sampled combinationally each cycle; a change mid-request only affects arbitration of not-yet-granted requests.

Test Plan:
- Reset then single CPU write: cpu_req=1, we=1, addr=0x0010, wdata=0xBEEF. Required: cpu_ack=1 in cycle 0; mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF in cycle 1; no cpu_rvalid.
- CPU read-back of 0x0010: cpu_rvalid=1 with cpu_rdata=0xBEEF exactly 2 cycles after cpu_ack; vga_rvalid stays 0.
- vga_blank=0, vga_req and cpu_req held high continuously, CPU_MAX_WAIT=4. Required grant pattern: VGA,VGA,VGA,VGA,CPU repeating; starve counter 0 after each CPU grant.
- vga_blank=1, both requesting. Required: CPU granted every cycle it requests; VGA granted only when cpu_req=0.
- VGA back-to-back reads addr 0x0100..0x0103 with cpu_req=0. Required: vga_ack high 4 consecutive cycles; vga_rvalid high 4 consecutive cycles starting 2 cycles later, data in address order.
- Assert BTN_NORTH one cycle after a VGA read grant, release 2 cycles later. Required: all outputs 0 during reset; no vga_rvalid for the dropped read; next request served with normal 2-cycle latency.
